// File: rtl/bytebeat_pkg.sv
// Shared definitions for the bytebeat synth and its PWM audio output stage.
//   SAMPLE_W       : width of one audio sample
//   sample_t       : unsigned sample type carried from bytebeat to pwm_out
//   PWM_IDLE_LEVEL : mid-scale level played when no sample has arrived yet
package bytebeat_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t PWM_IDLE_LEVEL = 8'h80;

endpackage

// File: rtl/pwm_out_if.sv
// Valid/ready sample channel between bytebeat (master) and pwm_out (slave).
//   sample_r     : unsigned audio sample
//   sample_r_vld : sample valid
//   sample_r_rdy : consumer can accept a sample this cycle
interface pwm_out_if;
    import bytebeat_pkg::*;

    sample_t sample_r;
    logic    sample_r_vld;
    logic    sample_r_rdy;

    modport master (output sample_r, output sample_r_vld, input sample_r_rdy);
    modport slave  (input sample_r, input sample_r_vld, output sample_r_rdy);

endinterface

// File: rtl/pwm_out_tick.sv
// Prescaler for the PWM phase counter.
//   clk   : clock
//   reset : synchronous active-high reset
//   tick  : high in the last clock of every PRESCALE-clock step
module pwm_out_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_direct
            // Every clock is a phase step; clk/reset are not needed here.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset};
            assign tick      = 1'b1;
        end else begin : g_count
            localparam int PS_W = $clog2(PRESCALE);
            localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

            logic [PS_W-1:0] ps_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ps_cnt <= '0;
                end else if (ps_cnt == PS_LAST) begin
                    ps_cnt <= '0;
                end else begin
                    ps_cnt <= ps_cnt + PS_W'(1);
                end
            end

            assign tick = (ps_cnt == PS_LAST);
        end
    endgenerate

endmodule

// File: rtl/pwm_out.sv
// First-order PWM audio output: takes one 8-bit sample per frame from a
// valid/ready channel and plays it as a duty cycle of active/256.
//   clk                  : clock
//   reset                : synchronous active-high reset
//   sample_ch            : sample channel (slave side)
//   pwm_out__pwm         : registered PWM pin
//   pwm_out__frame_start : one-cycle strobe after each frame boundary
//   pwm_out__underrun    : one-cycle strobe when a boundary found no sample
module pwm_out
    import bytebeat_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int REPEAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    pwm_out_if.slave        sample_ch,
    output logic            pwm_out__pwm,
    output logic            pwm_out__frame_start,
    output logic            pwm_out__underrun
);

    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);

    logic              tick;
    logic [7:0]        phase;
    logic [REP_W-1:0]  rep_cnt;
    sample_t           pend;
    logic              pend_vld;
    sample_t           active;
    logic              rep_last;
    logic              boundary;
    logic              xfer;
    logic              pwm_p1;
    logic              frame_start_p1;
    logic              underrun_p1;

    pwm_out_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rep_last = (rep_cnt == REP_LAST);
    assign boundary = tick & (phase == 8'hFF) & rep_last;

    // Ready depends only on registered state and reset, never on vld.
    assign sample_ch.sample_r_rdy = ~pend_vld & ~reset;
    assign xfer = sample_ch.sample_r_vld & sample_ch.sample_r_rdy;

    // ---- stage p0: frame position, holding register, active sample ----
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            rep_cnt  <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            active   <= PWM_IDLE_LEVEL;
        end else begin
            if (tick) begin
                phase <= phase + 8'd1;
                if (phase == 8'hFF) begin
                    rep_cnt <= rep_last ? '0 : rep_cnt + REP_W'(1);
                end
            end
            // A transfer needs pend_vld=0, so it never collides with the
            // pend-to-active move; a transfer on an empty boundary waits
            // in pend for the next frame.
            if (boundary && pend_vld) begin
                active   <= pend;
                pend_vld <= 1'b0;
            end else if (xfer) begin
                pend     <= sample_ch.sample_r;
                pend_vld <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered pin and strobes ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_p1         <= 1'b0;
            frame_start_p1 <= 1'b0;
            underrun_p1    <= 1'b0;
        end else begin
            pwm_p1         <= (phase < active);
            frame_start_p1 <= boundary;
            underrun_p1    <= boundary & ~pend_vld;
        end
    end

    assign pwm_out__pwm         = pwm_p1;
    assign pwm_out__frame_start = frame_start_p1;
    assign pwm_out__underrun    = underrun_p1;

endmodule

// File: tb/tb_pwm_out.sv
// Directed testbench for pwm_out: dut_a uses PRESCALE=1/REPEAT=1,
// dut_b uses PRESCALE=3/REPEAT=2 for the back-pressure scenario.
module tb_pwm_out;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    logic pwm_a, fs_a, ur_a;
    logic pwm_b, fs_b, ur_b;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;

    pwm_out_if a_if ();
    pwm_out_if b_if ();

    pwm_out #(.PRESCALE(1), .REPEAT(1)) dut_a (
        .clk                  (clk),
        .reset                (reset_a),
        .sample_ch            (a_if),
        .pwm_out__pwm         (pwm_a),
        .pwm_out__frame_start (fs_a),
        .pwm_out__underrun    (ur_a)
    );

    pwm_out #(.PRESCALE(3), .REPEAT(2)) dut_b (
        .clk                  (clk),
        .reset                (reset_b),
        .sample_ch            (b_if),
        .pwm_out__pwm         (pwm_b),
        .pwm_out__frame_start (fs_b),
        .pwm_out__underrun    (ur_b)
    );

    always #5 clk = ~clk;

    // Advance one clock; values are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Hold reset for a few cycles, release at a falling edge: cycle 0.
    task automatic a_release();
        reset_a = 1'b1;
        a_if.sample_r_vld = 1'b0;
        a_if.sample_r = 8'h00;
        repeat (3) @(negedge clk);
        reset_a = 1'b0;
        cyc = 0;
        #1;
    endtask

    task automatic test_reset();
        int hi1, hi2, fs_cnt, ur_cnt;
        hi1 = 0; hi2 = 0; fs_cnt = 0; ur_cnt = 0;
        reset_a = 1'b1;
        a_if.sample_r_vld = 1'b0;
        a_if.sample_r = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (a_if.sample_r_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy got %b want 0", a_if.sample_r_rdy); end
        n_cmp++; if (pwm_a !== 1'b0) begin n_bad++; $display("FAIL reset_pwm got %b want 0", pwm_a); end
        n_cmp++; if (fs_a !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %b want 0", fs_a); end
        n_cmp++; if (ur_a !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got %b want 0", ur_a); end
        @(negedge clk);
        reset_a = 1'b0;
        cyc = 0;
        #1;
        n_cmp++; if (a_if.sample_r_rdy !== 1'b1) begin n_bad++; $display("FAIL idle_rdy_c0 got %b want 1", a_if.sample_r_rdy); end
        while (cyc < 600) begin
            step();
            if (cyc >= 1 && cyc <= 256) hi1 += int'(pwm_a);
            if (cyc >= 257 && cyc <= 512) hi2 += int'(pwm_a);
            if (fs_a) fs_cnt++;
            if (ur_a) ur_cnt++;
            if (cyc == 256 || cyc == 512) begin
                n_cmp++; if (fs_a !== 1'b1 || ur_a !== 1'b1) begin n_bad++; $display("FAIL idle_strobes c%0d got fs=%b ur=%b want 1 1", cyc, fs_a, ur_a); end
            end
        end
        n_cmp++; if (hi1 != 128) begin n_bad++; $display("FAIL idle_duty_p1 got %0d want 128", hi1); end
        n_cmp++; if (hi2 != 128) begin n_bad++; $display("FAIL idle_duty_p2 got %0d want 128", hi2); end
        n_cmp++; if (fs_cnt != 2) begin n_bad++; $display("FAIL idle_fs_count got %0d want 2", fs_cnt); end
        n_cmp++; if (ur_cnt != 2) begin n_bad++; $display("FAIL idle_ur_count got %0d want 2", ur_cnt); end
    endtask

    task automatic test_single();
        int rdy_low, hi;
        rdy_low = 0; hi = 0;
        a_release();
        a_if.sample_r = 8'h40;
        a_if.sample_r_vld = 1'b1;
        while (cyc < 520) begin
            step();
            if (cyc == 1) a_if.sample_r_vld = 1'b0;
            if (cyc >= 1 && cyc <= 255 && a_if.sample_r_rdy == 1'b0) rdy_low++;
            if (cyc >= 257 && cyc <= 512) hi += int'(pwm_a);
            if (cyc == 256) begin
                n_cmp++; if (a_if.sample_r_rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy_c256 got %b want 1", a_if.sample_r_rdy); end
                n_cmp++; if (ur_a !== 1'b0 || fs_a !== 1'b1) begin n_bad++; $display("FAIL single_strobes_c256 got fs=%b ur=%b want 1 0", fs_a, ur_a); end
            end
            if (cyc == 512) begin
                n_cmp++; if (ur_a !== 1'b1) begin n_bad++; $display("FAIL single_ur_c512 got %b want 1", ur_a); end
            end
        end
        n_cmp++; if (rdy_low != 255) begin n_bad++; $display("FAIL single_rdy_low got %0d want 255", rdy_low); end
        n_cmp++; if (hi != 64) begin n_bad++; $display("FAIL single_duty got %0d want 64", hi); end
    endtask

    task automatic test_extremes();
        int hi0, hiff;
        hi0 = 0; hiff = 0;
        a_release();
        a_if.sample_r = 8'h00;
        a_if.sample_r_vld = 1'b1;
        while (cyc < 770) begin
            step();
            if (cyc == 1) a_if.sample_r = 8'hFF;
            if (cyc == 257) a_if.sample_r_vld = 1'b0;
            if (cyc >= 257 && cyc <= 512) hi0 += int'(pwm_a);
            if (cyc >= 513 && cyc <= 768) hiff += int'(pwm_a);
            if (cyc == 512) begin
                n_cmp++; if (ur_a !== 1'b0) begin n_bad++; $display("FAIL ext_ur_c512 got %b want 0", ur_a); end
            end
            if (cyc == 768) begin
                n_cmp++; if (pwm_a !== 1'b0) begin n_bad++; $display("FAIL ext_ff_low_step got %b want 0", pwm_a); end
            end
        end
        n_cmp++; if (hi0 != 0) begin n_bad++; $display("FAIL ext_zero_duty got %0d want 0", hi0); end
        n_cmp++; if (hiff != 255) begin n_bad++; $display("FAIL ext_ff_duty got %0d want 255", hiff); end
    endtask

    task automatic test_collision();
        int hi_a, hi_b;
        hi_a = 0; hi_b = 0;
        a_release();
        while (cyc < 770) begin
            step();
            if (cyc >= 257 && cyc <= 512) hi_a += int'(pwm_a);
            if (cyc >= 513 && cyc <= 768) hi_b += int'(pwm_a);
            if (cyc == 255) begin
                n_cmp++; if (a_if.sample_r_rdy !== 1'b1) begin n_bad++; $display("FAIL coll_rdy_c255 got %b want 1", a_if.sample_r_rdy); end
                a_if.sample_r = 8'h10;
                a_if.sample_r_vld = 1'b1;
            end
            if (cyc == 256) begin
                a_if.sample_r_vld = 1'b0;
                n_cmp++; if (ur_a !== 1'b1 || fs_a !== 1'b1) begin n_bad++; $display("FAIL coll_strobes_c256 got fs=%b ur=%b want 1 1", fs_a, ur_a); end
                n_cmp++; if (a_if.sample_r_rdy !== 1'b0) begin n_bad++; $display("FAIL coll_rdy_c256 got %b want 0", a_if.sample_r_rdy); end
            end
            if (cyc == 512) begin
                n_cmp++; if (ur_a !== 1'b0) begin n_bad++; $display("FAIL coll_ur_c512 got %b want 0", ur_a); end
            end
        end
        n_cmp++; if (hi_a != 128) begin n_bad++; $display("FAIL coll_idle_frame got %0d want 128", hi_a); end
        n_cmp++; if (hi_b != 16) begin n_bad++; $display("FAIL coll_played got %0d want 16", hi_b); end
    endtask

    task automatic test_reset_mid();
        int fs_early, hi;
        fs_early = 0; hi = 0;
        a_release();
        a_if.sample_r = 8'h40;
        a_if.sample_r_vld = 1'b1;
        while (cyc < 100) begin
            step();
            if (cyc == 1) a_if.sample_r_vld = 1'b0;
        end
        n_cmp++; if (pwm_a !== 1'b1) begin n_bad++; $display("FAIL mid_pwm_before got %b want 1", pwm_a); end
        reset_a = 1'b1;
        #1;
        n_cmp++; if (a_if.sample_r_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rdy_in_reset got %b want 0", a_if.sample_r_rdy); end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (pwm_a !== 1'b0 || fs_a !== 1'b0 || ur_a !== 1'b0) begin n_bad++; $display("FAIL mid_outputs got pwm=%b fs=%b ur=%b want 0 0 0", pwm_a, fs_a, ur_a); end
        @(negedge clk);
        reset_a = 1'b0;
        cyc = 0;
        #1;
        n_cmp++; if (a_if.sample_r_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rdy_c0 got %b want 1", a_if.sample_r_rdy); end
        while (cyc < 520) begin
            step();
            if (cyc <= 255 && fs_a) fs_early++;
            if (cyc >= 257 && cyc <= 512) hi += int'(pwm_a);
            if (cyc == 256) begin
                n_cmp++; if (fs_a !== 1'b1 || ur_a !== 1'b1) begin n_bad++; $display("FAIL mid_first_boundary got fs=%b ur=%b want 1 1", fs_a, ur_a); end
            end
        end
        n_cmp++; if (fs_early != 0) begin n_bad++; $display("FAIL mid_early_fs got %0d want 0", fs_early); end
        n_cmp++; if (hi != 128) begin n_bad++; $display("FAIL mid_idle_duty got %0d want 128", hi); end
    endtask

    task automatic test_back_to_back();
        int xfer_cyc[$];
        int hi[5];
        int fs_cnt, ur_cnt;
        logic took;
        logic [7:0] want_cnt;
        fs_cnt = 0; ur_cnt = 0;
        for (int i = 0; i < 5; i++) hi[i] = 0;
        reset_b = 1'b1;
        b_if.sample_r_vld = 1'b0;
        b_if.sample_r = 8'h00;
        repeat (3) @(negedge clk);
        reset_b = 1'b0;
        cyc = 0;
        b_if.sample_r = 8'd16;
        b_if.sample_r_vld = 1'b1;
        #1;
        while (cyc < 6150) begin
            took = b_if.sample_r_rdy & b_if.sample_r_vld;
            if (took) xfer_cyc.push_back(cyc);
            step();
            if (took) b_if.sample_r = b_if.sample_r + 8'd16;
            hi[(cyc - 1) / 1536] += int'(pwm_b);
            if (fs_b) fs_cnt++;
            if (ur_b) ur_cnt++;
        end
        b_if.sample_r_vld = 1'b0;
        want_cnt = 8'd5;
        n_cmp++; if (xfer_cyc.size() != int'(want_cnt)) begin n_bad++; $display("FAIL b2b_xfer_count got %0d want 5", xfer_cyc.size()); end
        for (int i = 0; i < xfer_cyc.size() && i < 5; i++) begin
            n_cmp++; if (xfer_cyc[i] != 1536 * i) begin n_bad++; $display("FAIL b2b_xfer_cycle[%0d] got %0d want %0d", i, xfer_cyc[i], 1536 * i); end
        end
        n_cmp++; if (hi[0] != 768) begin n_bad++; $display("FAIL b2b_frame0 got %0d want 768", hi[0]); end
        n_cmp++; if (hi[1] != 96) begin n_bad++; $display("FAIL b2b_frame1 got %0d want 96", hi[1]); end
        n_cmp++; if (hi[2] != 192) begin n_bad++; $display("FAIL b2b_frame2 got %0d want 192", hi[2]); end
        n_cmp++; if (hi[3] != 288) begin n_bad++; $display("FAIL b2b_frame3 got %0d want 288", hi[3]); end
        n_cmp++; if (fs_cnt != 4) begin n_bad++; $display("FAIL b2b_fs_count got %0d want 4", fs_cnt); end
        n_cmp++; if (ur_cnt != 0) begin n_bad++; $display("FAIL b2b_underruns got %0d want 0", ur_cnt); end
    endtask

    initial begin
        a_if.sample_r = 8'h00;
        a_if.sample_r_vld = 1'b0;
        b_if.sample_r = 8'h00;
        b_if.sample_r_vld = 1'b0;
        cyc = 0;
        test_reset();
        test_single();
        test_extremes();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
